mc_state_seq: RTL and testbench
===============================

// Module: mc_state_seq
// PURPOSE
//  Parametrised control-state register for the multicycle CPU control unit.
//  Holds the current control state; next state comes from hold/load/increment/
//  return-to-fetch ops. A DEPTH-entry LIFO saves and restores state for trap entry/return.
//  Sits between the next-state decode logic and the control-signal ROM.
// PARAMETERS
//  WIDTH       4    state width in bits (2..8)
//  DEPTH       4    save-stack entries (1..16, power of 2 not required)
//  RESET_STATE 0    state after rst and after the FETCH op (WIDTH bits)
//  WD_LIMIT    64   watchdog limit in cycles (only with STATESEQ_WATCHDOG_EN)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  stall      in   1      1: freeze state, stack and watchdog counter
//  op         in   2      00 HOLD, 01 LOAD din, 10 INC, 11 FETCH (=RESET_STATE)
//  din        in   WIDTH  load value for LOAD
//  push       in   1      save current state_q onto stack
//  pop        in   1      restore stack top into state_q (overrides op)
//  state_q    out  WIDTH  current control state (registered)
//  stk_empty  out  1      stack holds 0 entries
//  stk_full   out  1      stack holds DEPTH entries
//  stk_err    out  1      sticky: push-when-full or pop-when-empty seen
//  wd_timeout out  1      1-cycle pulse: watchdog forced FETCH
// BEHAVIOUR
//  - All updates on posedge clk. Outputs are registered or decoded from sp only.
//  - rst: state_q=RESET_STATE, sp=0, stk_empty=1, stk_full=0, stk_err=0,
//    wd_timeout=0, wd count=0. rst has priority over every other input, including mid-op.
//  - stall=1 (no rst): state_q, sp, stack, wd count all hold. push/pop/op ignored.
//    stk_err and wd_timeout deassert/hold as if no event (wd_timeout goes 0).
//  - Next state when not stalled, in priority order:
//    pop and stack non-empty -> stack top.
//    Otherwise by op: HOLD=state_q, LOAD=din, INC=state_q+1 mod 2^WIDTH
//    (all-ones wraps to 0), FETCH=RESET_STATE.
//  - push only, not full: stack[sp]<=state_q (pre-update value), sp++.
//    Next state still follows op.
//  - pop only, not empty: sp--, state_q<=stack[sp-1].
//  - push+pop, stack non-empty: swap. state_q<=top, top<=old state_q, sp unchanged.
//  - push+pop, stack empty: push is performed, pop is ignored, stk_err set.
//    Next state follows op.
//  - push when full (without pop): ignored, stk_err<=1.
//  - pop when empty: ignored, stk_err<=1, next state follows op.
//  - stk_err clears only on rst. stk_full/stk_empty are valid the cycle after the sp change.
//  - Latency: any op/pop is visible on state_q one cycle after the sampling edge.
// CONFIGURATION
//  STATESEQ_WATCHDOG_EN defined:
//    - A ceil(log2(WD_LIMIT+1))-bit counter counts unstalled cycles in which
//      next state == state_q. It resets to 0 when the state changes.
//    - When the count would reach WD_LIMIT: state_q<=RESET_STATE, count<=0,
//      wd_timeout=1 for that cycle's result (one cycle).
//    - The watchdog overrides op and pop. The stack is untouched, but a
//      simultaneous push still occurs.
//  STATESEQ_WATCHDOG_EN undefined: no counter; wd_timeout tied 0; WD_LIMIT unused.
// TESTING
//  T1 reset: rst=1 with any inputs for 2 cycles -> state_q=0, stk_empty=1,
//     stk_full=0, stk_err=0, wd_timeout=0.
//  T2 wrap: LOAD din=4'hE, then INC x2 -> state_q 4'hE, 4'hF, 4'h0.
//     Then FETCH -> 0. stall=1 during INC -> state_q unchanged.
//  T3 stack: state 3 push+LOAD 7, state 7 push+LOAD 9, pop -> 7, pop -> 3,
//     stk_empty=1, stk_err=0.
//  T4 errors: DEPTH=4, 5 pushes -> stk_full=1 after 4th, stk_err=1 after 5th,
//     contents intact. Pop from empty after rst -> stk_err=1, state follows op.
//  T5 swap: state 5, stack top 2, push+pop -> state_q=2, top=5, sp unchanged.
//  T6 (WATCHDOG_EN, WD_LIMIT=8): LOAD 6 then HOLD -> after 8 held cycles
//     state_q=0, wd_timeout 1-cycle pulse. Same with stall=1 throughout -> no timeout.

Source files
------------

// File: rtl/mc_state_seq.sv
// mc_state_seq: control-state register for the multicycle CPU control unit.
// Holds the current control state. The next state comes from a
// hold/load/increment/fetch op, or from a DEPTH-entry LIFO used to save and
// restore state around trap entry and return.
// Optional feature macro: STATESEQ_WATCHDOG_EN. When it is defined, a
// watchdog forces FETCH once the state has been held for WD_LIMIT unstalled
// cycles.
module mc_state_seq #(
   parameter int unsigned      WIDTH       = 4,
   parameter int unsigned      DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_STATE = '0,
   parameter int unsigned      WD_LIMIT    = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] din,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] state_q,
   output logic             stk_empty,
   output logic             stk_full,
   output logic             stk_err,
   output logic             wd_timeout
);

   // sp counts 0..DEPTH. The stack index only needs to address DEPTH entries.
   localparam int unsigned SPW = $clog2(DEPTH + 1);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      OpHold  = 2'b00,
      OpLoad  = 2'b01,
      OpInc   = 2'b10,
      OpFetch = 2'b11
   } op_e;

   logic [SPW-1:0]   sp_q, sp_d;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] state_d, nxt_state, top;
   logic [AW-1:0]    top_idx, push_idx, stk_widx;
   logic             stk_we;
   logic             err_d, wd_d;
   logic             wd_fire, pop_eff;

   assign stk_empty = (sp_q == '0);
   assign stk_full  = (sp_q == SPW'(DEPTH));
   assign top_idx   = AW'(sp_q - SPW'(1));
   assign push_idx  = AW'(sp_q);
   assign top       = stack_q[top_idx];

   // Candidate next state before any watchdog override; a pop of a non-empty stack wins over op
   always_comb begin
      nxt_state = state_q;
      unique case (op_e'(op))
         OpHold:  nxt_state = state_q;
         OpLoad:  nxt_state = din;
         OpInc:   nxt_state = state_q + WIDTH'(1);
         OpFetch: nxt_state = RESET_STATE;
      endcase
      if (pop && !stk_empty) begin
         nxt_state = top;
      end
   end

`ifdef STATESEQ_WATCHDOG_EN
   localparam int unsigned WDW = $clog2(WD_LIMIT + 1);
   logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

   // Count unstalled cycles without a state change; fire when the count would hit WD_LIMIT
   always_comb begin
      wd_fire  = 1'b0;
      wd_cnt_d = wd_cnt_q;
      if (!stall) begin
         if (nxt_state != state_q) begin
            wd_cnt_d = '0;
         end else if (wd_cnt_q == WDW'(WD_LIMIT - 1)) begin
            wd_fire  = 1'b1;
            wd_cnt_d = '0;
         end else begin
            wd_cnt_d = wd_cnt_q + WDW'(1);
         end
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk) begin
      if (rst) wd_cnt_q <= '0;
      else     wd_cnt_q <= wd_cnt_d;
   end
`else
   logic unused_wd_limit;
   assign unused_wd_limit = ^WD_LIMIT;
   assign wd_fire         = 1'b0;
`endif

   // A watchdog FETCH leaves the stack alone, so it cancels the pop but not a push
   assign pop_eff = pop & ~wd_fire;

   // Next state, stack pointer, stack write and error flag
   always_comb begin
      state_d   = state_q;
      sp_d      = sp_q;
      err_d     = stk_err;
      wd_d      = 1'b0;
      stk_we    = 1'b0;
      stk_widx  = push_idx;
      if (!stall) begin
         state_d = wd_fire ? RESET_STATE : nxt_state;
         wd_d    = wd_fire;
         if (pop_eff && !stk_empty) begin
            if (push) begin
               // Swap: top takes the old state, sp unchanged
               stk_we   = 1'b1;
               stk_widx = top_idx;
            end else begin
               sp_d = sp_q - SPW'(1);
            end
         end else if (push) begin
            if (!stk_full) begin
               stk_we = 1'b1;
               sp_d   = sp_q + SPW'(1);
            end else begin
               err_d = 1'b1;
            end
         end
         if (pop && stk_empty) begin
            err_d = 1'b1;
         end
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RESET_STATE;
         sp_q       <= '0;
         stk_err    <= 1'b0;
         wd_timeout <= 1'b0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         stk_err    <= err_d;
         wd_timeout <= wd_d;
      end
   end

   // Stack storage; contents need no reset since sp gates every read
   always_ff @(posedge clk) begin
      if (!rst && stk_we) begin
         stack_q[stk_widx] <= state_q;
      end
   end

endmodule

// File: tb/tb_mc_state_seq.sv
// Directed bench for mc_state_seq (WIDTH=4, DEPTH=4, RESET_STATE=0, WD_LIMIT=8).
module tb_mc_state_seq;

   logic       clk = 1'b0;
   logic       rst, stall, push, pop;
   logic [1:0] op;
   logic [3:0] din;
   logic [3:0] state_q;
   logic       stk_empty, stk_full, stk_err, wd_timeout;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, INC = 2'b10, FETCH = 2'b11;

   mc_state_seq #(
      .WIDTH       (4),
      .DEPTH       (4),
      .RESET_STATE (4'h0),
      .WD_LIMIT    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .op         (op),
      .din        (din),
      .push       (push),
      .pop        (pop),
      .state_q    (state_q),
      .stk_empty  (stk_empty),
      .stk_full   (stk_full),
      .stk_err    (stk_err),
      .wd_timeout (wd_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   // Apply one set of inputs for one clock edge, then sample 1 time unit later
   task automatic step(input logic s, input logic [1:0] o, input logic [3:0] d,
                       input logic pu, input logic po);
      stall = s; op = o; din = d; push = pu; pop = po;
      @(posedge clk);
      #1;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      step(1'b0, HOLD, 4'h0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; op = HOLD; din = '0; push = 1'b0; pop = 1'b0;

      // T1: reset dominates busy inputs for two cycles
      step(1'b0, LOAD, 4'h9, 1'b1, 1'b1);
      step(1'b1, INC, 4'h5, 1'b1, 1'b0);
      chk("t1_state", {4'h0, state_q}, 8'h00);
      chk("t1_empty", {7'h0, stk_empty}, 8'h01);
      chk("t1_full", {7'h0, stk_full}, 8'h00);
      chk("t1_err", {7'h0, stk_err}, 8'h00);
      chk("t1_wd", {7'h0, wd_timeout}, 8'h00);
      rst = 1'b0;

      // T2: load, increment wrap, stall, fetch
      step(1'b0, LOAD, 4'hE, 1'b0, 1'b0);
      chk("t2_load_e", {4'h0, state_q}, 8'h0E);
      step(1'b0, INC, 4'h0, 1'b0, 1'b0);
      chk("t2_inc_f", {4'h0, state_q}, 8'h0F);
      step(1'b1, INC, 4'h0, 1'b1, 1'b1);
      chk("t2_stall_state", {4'h0, state_q}, 8'h0F);
      chk("t2_stall_empty", {7'h0, stk_empty}, 8'h01);
      chk("t2_stall_err", {7'h0, stk_err}, 8'h00);
      step(1'b0, INC, 4'h0, 1'b0, 1'b0);
      chk("t2_wrap_0", {4'h0, state_q}, 8'h00);
      step(1'b0, LOAD, 4'h5, 1'b0, 1'b0);
      step(1'b0, FETCH, 4'hA, 1'b0, 1'b0);
      chk("t2_fetch", {4'h0, state_q}, 8'h00);

      // T3: nested save and restore
      step(1'b0, LOAD, 4'h3, 1'b0, 1'b0);
      step(1'b0, LOAD, 4'h7, 1'b1, 1'b0);
      chk("t3_push1_state", {4'h0, state_q}, 8'h07);
      chk("t3_push1_empty", {7'h0, stk_empty}, 8'h00);
      step(1'b0, LOAD, 4'h9, 1'b1, 1'b0);
      chk("t3_push2_state", {4'h0, state_q}, 8'h09);
      step(1'b0, INC, 4'h0, 1'b0, 1'b1);
      chk("t3_pop1", {4'h0, state_q}, 8'h07);
      step(1'b0, HOLD, 4'h0, 1'b0, 1'b1);
      chk("t3_pop2", {4'h0, state_q}, 8'h03);
      chk("t3_empty", {7'h0, stk_empty}, 8'h01);
      chk("t3_err", {7'h0, stk_err}, 8'h00);

      // T5: swap with push+pop on a non-empty stack
      step(1'b0, LOAD, 4'h2, 1'b0, 1'b0);
      step(1'b0, LOAD, 4'h5, 1'b1, 1'b0);
      step(1'b0, HOLD, 4'h0, 1'b1, 1'b1);
      chk("t5_swap_state", {4'h0, state_q}, 8'h02);
      chk("t5_swap_empty", {7'h0, stk_empty}, 8'h00);
      chk("t5_swap_err", {7'h0, stk_err}, 8'h00);
      step(1'b0, HOLD, 4'h0, 1'b0, 1'b1);
      chk("t5_top_was_5", {4'h0, state_q}, 8'h05);
      chk("t5_empty_after", {7'h0, stk_empty}, 8'h01);

      // T4: overflow, contents survive, then underflow
      do_rst();
      step(1'b0, LOAD, 4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, INC, 4'h0, 1'b1, 1'b0);
      chk("t4_not_full_3", {7'h0, stk_full}, 8'h00);
      step(1'b0, INC, 4'h0, 1'b1, 1'b0);
      chk("t4_full_4", {7'h0, stk_full}, 8'h01);
      chk("t4_err_4", {7'h0, stk_err}, 8'h00);
      step(1'b0, INC, 4'h0, 1'b1, 1'b0);
      chk("t4_err_5", {7'h0, stk_err}, 8'h01);
      chk("t4_state_5", {4'h0, state_q}, 8'h06);
      for (int i = 4; i >= 1; i--) begin
         step(1'b0, HOLD, 4'h0, 1'b0, 1'b1);
         chk($sformatf("t4_pop_%0d", i), {4'h0, state_q}, 8'(i));
      end
      chk("t4_empty", {7'h0, stk_empty}, 8'h01);
      do_rst();
      chk("t4_err_cleared", {7'h0, stk_err}, 8'h00);
      step(1'b0, LOAD, 4'hA, 1'b0, 1'b1);
      chk("t4_underflow_state", {4'h0, state_q}, 8'h0A);
      chk("t4_underflow_err", {7'h0, stk_err}, 8'h01);
      chk("t4_underflow_empty", {7'h0, stk_empty}, 8'h01);
      // push+pop on empty: push happens, pop ignored
      do_rst();
      step(1'b0, LOAD, 4'h8, 1'b1, 1'b1);
      chk("t4_pp_empty_state", {4'h0, state_q}, 8'h08);
      chk("t4_pp_empty_err", {7'h0, stk_err}, 8'h01);
      chk("t4_pp_empty_sp", {7'h0, stk_empty}, 8'h00);
      step(1'b0, HOLD, 4'h0, 1'b0, 1'b1);
      chk("t4_pp_empty_saved", {4'h0, state_q}, 8'h00);
      chk("t4_wd_off", {7'h0, wd_timeout}, 8'h00);

`ifdef STATESEQ_WATCHDOG_EN
      // T6: eight held cycles trigger FETCH with a one-cycle pulse
      do_rst();
      step(1'b0, LOAD, 4'h6, 1'b0, 1'b0);
      for (int i = 1; i <= 7; i++) begin
         step(1'b0, HOLD, 4'h0, 1'b0, 1'b0);
         chk($sformatf("t6_hold_%0d", i), {3'h0, wd_timeout, state_q}, 8'h06);
      end
      step(1'b0, HOLD, 4'h0, 1'b0, 1'b0);
      chk("t6_fire_state", {4'h0, state_q}, 8'h00);
      chk("t6_fire_pulse", {7'h0, wd_timeout}, 8'h01);
      step(1'b0, HOLD, 4'h0, 1'b0, 1'b0);
      chk("t6_pulse_end", {7'h0, wd_timeout}, 8'h00);
      step(1'b0, LOAD, 4'h6, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, HOLD, 4'h0, 1'b0, 1'b0);
      chk("t6_stall_state", {4'h0, state_q}, 8'h06);
      chk("t6_stall_pulse", {7'h0, wd_timeout}, 8'h00);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
